// File: rtl/uart_pkg.sv
// Shared UART definitions: data widths and the receive FIFO entry layout.
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int RX_ENTRY_W  = 10;

  typedef struct packed {
    logic                   pe;
    logic                   fe;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port, no reset.
module uart_fifo_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind uart_top: first-word-fall-through output, overflow flag and drop counter.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rx_ready,
  input  logic [7:0]               rx_data,
  input  logic                     framing_error,
  input  logic                     parity_error,
  input  logic                     flush,
  input  logic                     clr_ovf,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [7:0]               m_data,
  output logic                     m_fe,
  output logic                     m_pe,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [7:0]               ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_AF  = (AW+1)'(AF_LEVEL);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    ovf_cnt_q, ovf_cnt_d;

  logic      push, pop, full, wr_en, drop;
  rx_entry_t wr_entry, rd_entry;

  assign m_valid  = (level_q != '0);
  assign full     = (level_q == LVL_MAX);
  assign push     = rx_ready & ~flush;
  assign pop      = m_valid & m_ready & ~flush;
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign wr_en    = push & (~full | pop);
  assign drop     = push & full & ~pop;
  assign wr_entry = '{pe: parity_error, fe: framing_error, data: rx_data};

  uart_fifo_mem #(
    .WIDTH (RX_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata (wr_entry),
    .raddr (rptr_q),
    .rdata (rd_entry)
  );

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    level_d       = level_q;
    overflow_d    = overflow_q;
    ovf_cnt_d     = ovf_cnt_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PTR_ONE;
      if (pop)   rptr_d = rptr_q + PTR_ONE;
      if (wr_en && !pop)      level_d = level_q + LVL_ONE;
      else if (!wr_en && pop) level_d = level_q - LVL_ONE;
    end
    // A drop outranks a simultaneous clear so the lost byte is never hidden.
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_ovf)                 ovf_cnt_d = 8'd1;
      else if (ovf_cnt_q != 8'hFF) ovf_cnt_d = ovf_cnt_q + 8'd1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      ovf_cnt_d  = 8'd0;
    end
    almost_full_d = (level_d >= LVL_AF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      level_q       <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      ovf_cnt_q     <= 8'd0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      level_q       <= level_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
      ovf_cnt_q     <= ovf_cnt_d;
    end
  end

  assign m_data      = m_valid ? rd_entry.data : 8'd0;
  assign m_fe        = m_valid & rd_entry.fe;
  assign m_pe        = m_valid & rd_entry.pe;
  assign level       = level_q;
  assign almost_full = almost_full_q;
  assign overflow    = overflow_q;
  assign ovf_cnt     = ovf_cnt_q;

endmodule
